// File: rtl/mem_pkg.sv
// Shared constants for the data memory responder: RV32I access-size codes and FSM encoding.
`timescale 1ns/1ps
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane write-enable generation for stores and lane extraction/extension for loads.
`timescale 1ns/1ps
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_shifted,
    output logic [31:0] rdata_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = rword[{addr, 3'b000} +: 8];
    assign w_half = addr[1] ? rword[31:16] : rword[15:0];

    // Unsigned codes never write: a store with them is rejected upstream.
    always_comb begin
        byte_en       = 4'b0000;
        wdata_shifted = wdata;
        rdata_ext     = 32'h0;
        case (funct3)
            F3_B: begin
                byte_en       = 4'b0001 << addr;
                wdata_shifted = {4{wdata[7:0]}};
                rdata_ext     = {{24{w_byte[7]}}, w_byte};
            end
            F3_BU: rdata_ext = {24'h0, w_byte};
            F3_H: begin
                byte_en       = addr[1] ? 4'b1100 : 4'b0011;
                wdata_shifted = {2{wdata[15:0]}};
                rdata_ext     = {{16{w_half[15]}}, w_half};
            end
            F3_HU: rdata_ext = {16'h0, w_half};
            F3_W: begin
                byte_en       = 4'b1111;
                wdata_shifted = wdata;
                rdata_ext     = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with fixed access latency and RV32I byte/half/word semantics.
`timescale 1ns/1ps
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_do_access;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rword;
    logic [3:0]       w_byte_en;
    logic [31:0]      w_wdata_shifted;
    logic [31:0]      w_rdata_ext;

    function automatic logic access_err(input logic [2:0] f3, input logic wr,
                                        input logic [31:0] addr);
        logic e;
        case (f3)
            F3_B, F3_BU: e = 1'b0;
            F3_H, F3_HU: e = addr[0];
            F3_W:        e = |addr[1:0];
            default:     e = 1'b1;
        endcase
        if (wr && f3[2])
            e = 1'b1;
        if ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS))
            e = 1'b1;
        return e;
    endfunction

    assign w_accept    = (r_state == IDLE) && req_valid;
    assign w_do_access = (r_state == ACCESS) && (r_cnt == 4'd0);
    assign w_err       = access_err(r_funct3, r_write, r_addr);
    assign w_idx       = r_addr[IDX_W+1:2];
    assign w_rword     = r_mem[w_idx];

    mem_lane_align u_align (
        .funct3        (r_funct3),
        .addr          (r_addr[1:0]),
        .wdata         (r_wdata),
        .rword         (w_rword),
        .byte_en       (w_byte_en),
        .wdata_shifted (w_wdata_shifted),
        .rdata_ext     (w_rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    w_next_state = ACCESS;
            end
            ACCESS: if (r_cnt == 4'd0) w_next_state = RESP;
            RESP:   if (rsp_ready)     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept)
                r_cnt <= CNT_INIT;
            else if (r_state == ACCESS && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (w_do_access) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || r_write) ? 32'h0 : w_rdata_ext;
            end else if (r_state == RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
    end

    // Storage is deliberately outside reset; an aborted store never reaches this edge.
    always_ff @(posedge clk) begin
        if (rst && w_do_access && r_write && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byte_en[b])
                    r_mem[w_idx][8*b +: 8] <= w_wdata_shifted[8*b +: 8];
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-array reference model.
`timescale 1ns/1ps
module tb_data_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem_b [0:4095];
    bit          outstanding = 1'b0;
    bit          mon_en = 1'b0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [31:0] exp_rdata = 32'h0;
    bit          exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: access size from funct3[1:0], error rules, little-endian byte assembly.
    task automatic model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         output logic [31:0] rd, output bit er);
        int sz;
        logic [31:0] v;
        sz = 1 << f3[1:0];
        er = 1'b0;
        rd = 32'h0;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) er = 1'b1;
        if (wr && f3[2]) er = 1'b1;
        if ((int'(a[1:0]) % sz) != 0) er = 1'b1;
        if ((a >> 2) >= 32'(DEPTH)) er = 1'b1;
        if (!er && !wr) begin
            v = 32'h0;
            for (int i = 0; i < sz; i++)
                v = v | (32'(mem_b[int'(a[11:0]) + i]) << (8 * i));
            if (!f3[2] && sz < 4 && v[8*sz-1])
                v = v | ~((32'd1 << (8 * sz)) - 32'd1);
            rd = v;
        end
    endtask

    task automatic commit_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int sz;
        sz = 1 << f3[1:0];
        for (int i = 0; i < sz; i++)
            mem_b[int'(a[11:0]) + i] = wd[8*i +: 8];
    endtask

    always @(negedge clk) begin
        bit exp_v;
        cyc++;
        if (mon_en) begin
            exp_v = outstanding && ((cyc - acc_cyc) > LAT);
            chk("req_ready", 32'(req_ready), 32'(!outstanding));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
            if (exp_v) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
        end
    end

    task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, input bit pulse,
                          output logic [31:0] rd, output logic er);
        logic [31:0] mrd;
        bit mer;
        int lat;
        model(wr, f3, a, mrd, mer);
        exp_rdata  = mrd;
        exp_err    = mer;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid   = 1'b0;
        outstanding = 1'b1;
        acc_cyc     = cyc;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            req_valid = 1'($urandom % 2);
            rsp_ready = 1'($urandom % 2);
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("latency", 32'(lat), 32'(LAT));
        rd = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = pulse && (i == 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready   = 1'b0;
        outstanding = 1'b0;
        if (wr && !mer)
            commit_store(f3, a, wd);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset rsp_err", 32'(rsp_err), 32'h0);
        chk("reset req_ready", 32'(req_ready), 32'h1);
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk("req_ready after release", 32'(req_ready), 32'h1);

        for (int w = 0; w < 64; w++)
            do_req(1'b1, 3'b010, 32'(w * 4), $urandom, 0, 1'b0, rd, er);

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd, er);
        chk("S1 SW err", 32'(er), 32'h0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd, er);
        chk("S1 LW", rd, 32'hDEADBEEF);
        chk("S1 LW err", 32'(er), 32'h0);

        do_req(1'b0, 3'b000, 32'h13, 32'h0, 0, 1'b0, rd, er);
        chk("S2 LB", rd, 32'hFFFFFFDE);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 1, 1'b0, rd, er);
        chk("S2 LBU", rd, 32'h000000DE);
        do_req(1'b0, 3'b001, 32'h10, 32'h0, 0, 1'b0, rd, er);
        chk("S2 LH", rd, 32'hFFFFBEEF);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 2, 1'b0, rd, er);
        chk("S2 LHU", rd, 32'h0000DEAD);

        do_req(1'b1, 3'b000, 32'h11, 32'h12345677, 0, 1'b0, rd, er);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd, er);
        chk("S3 SB then LW", rd, 32'hDEAD77EF);
        do_req(1'b1, 3'b001, 32'h12, 32'hAAAA5555, 0, 1'b0, rd, er);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd, er);
        chk("S3 SH then LW", rd, 32'h555577EF);

        do_req(1'b0, 3'b010, 32'h12, 32'h0, 0, 1'b0, rd, er);
        chk("S4 LW misaligned err", 32'(er), 32'h1);
        chk("S4 LW misaligned rdata", rd, 32'h0);
        do_req(1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 0, 1'b0, rd, er);
        chk("S4 SH misaligned err", 32'(er), 32'h1);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 0, 1'b0, rd, er);
        chk("S4 funct3 011 err", 32'(er), 32'h1);
        chk("S4 funct3 011 rdata", rd, 32'h0);
        do_req(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 0, 1'b0, rd, er);
        chk("S4 store 100 err", 32'(er), 32'h1);
        do_req(1'b0, 3'b010, 32'h1000, 32'h0, 0, 1'b0, rd, er);
        chk("S4 out of range err", 32'(er), 32'h1);
        chk("S4 out of range rdata", rd, 32'h0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd, er);
        chk("S4 word unchanged", rd, 32'h555577EF);

        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, 1'b1, rd, er);
        chk("S5 held LW", rd, 32'h555577EF);

        do_req(1'b1, 3'b010, 32'h20, 32'h11223344, 0, 1'b0, rd, er);
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h0000FFFF;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid   = 1'b0;
        outstanding = 1'b1;
        acc_cyc     = cyc;
        rst         = 1'b0;
        @(posedge clk); #1;
        outstanding = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b0, rd, er);
        chk("S6 aborted store", rd, 32'h11223344);

        for (int n = 0; n < 300; n++) begin
            if ($urandom % 8 == 0)
                a = 32'h1000 + ($urandom % 64);
            else
                a = $urandom % 256;
            do_req(1'($urandom % 2), 3'($urandom % 8), a, $urandom,
                   int'($urandom % 4), 1'($urandom % 2), rd, er);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
